// File: rtl/auth_unit.sv
// ============================================================================
// auth_unit
// ----------------------------------------------------------------------------
// Purpose:
//   Credential entry and verification for the game controller. Digits arrive
//   as single-cycle pulses from a debounced keypad and are shifted into an
//   entry register. On a submit pulse the entry is compared against a stored
//   password. The block reports its status on a 2-bit code:
//      2'b00  awaiting entry
//      2'b01  correct (held until reset)
//      2'b10  incorrect (held for FAIL_HOLD cycles, then back to entry)
//      2'b11  locked out after MAX_TRIES failures (held until reset)
//
// Parameters:
//   CODE_LEN   digits per credential
//   DIGIT_W    bits per digit
//   PASSWORD   stored code, first-entered digit in the MSBs
//   MAX_TRIES  failed attempts allowed before lockout (>= 1)
//   FAIL_HOLD  cycles the incorrect status is held (>= 2)
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active low
//   digit_in     digit value, sampled while digit_valid is high
//   digit_valid  single-cycle digit strobe
//   enter        single-cycle submit strobe
//   clear        single-cycle strobe discarding the partial entry
//   s_auth       registered status code (see above)
//   code_out     digits entered so far, most recent digit in the LSBs
//   digit_count  number of digits entered so far
//   tries_left   remaining attempts before lockout
// ============================================================================
module auth_unit #(
   parameter int                             CODE_LEN  = 4,
   parameter int                             DIGIT_W   = 4,
   parameter logic [CODE_LEN*DIGIT_W-1:0]    PASSWORD  = 16'h1234,
   parameter int                             MAX_TRIES = 3,
   parameter int                             FAIL_HOLD = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [DIGIT_W-1:0]                  digit_in,
   input  logic                                digit_valid,
   input  logic                                enter,
   input  logic                                clear,
   output logic [1:0]                          s_auth,
   output logic [CODE_LEN*DIGIT_W-1:0]         code_out,
   output logic [$clog2(CODE_LEN+1)-1:0]       digit_count,
   output logic [$clog2(MAX_TRIES+1)-1:0]      tries_left
);

   localparam int CODE_W = CODE_LEN * DIGIT_W;
   localparam int CNT_W  = $clog2(CODE_LEN + 1);
   localparam int TRY_W  = $clog2(MAX_TRIES + 1);
   localparam int HOLD_W = $clog2(FAIL_HOLD + 1);

   localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(CODE_LEN);
   localparam logic [TRY_W-1:0]  TRIES_INIT = TRY_W'(MAX_TRIES);
   localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(FAIL_HOLD - 1);

   localparam logic [1:0] AUTH_WAIT = 2'b00;
   localparam logic [1:0] AUTH_OK   = 2'b01;
   localparam logic [1:0] AUTH_BAD  = 2'b10;
   localparam logic [1:0] AUTH_LOCK = 2'b11;

   typedef enum logic [2:0] {
      ST_ENTRY,
      ST_CHECK,
      ST_PASS,
      ST_FAIL,
      ST_LOCK
   } state_t;

   state_t              r_state;
   state_t              w_stateNext;
   logic [1:0]          r_auth;
   logic [1:0]          w_authNext;
   logic [CODE_W-1:0]   r_code;
   logic [CODE_W-1:0]   w_codeNext;
   logic [CNT_W-1:0]    r_count;
   logic [CNT_W-1:0]    w_countNext;
   logic [TRY_W-1:0]    r_tries;
   logic [TRY_W-1:0]    w_triesNext;
   logic [HOLD_W-1:0]   r_hold;
   logic [HOLD_W-1:0]   w_holdNext;

   logic                w_match;
   logic [TRY_W-1:0]    w_triesDec;
   logic [CODE_W-1:0]   w_codeShifted;

   // A short entry can never match, even if its zero-padded value happens
   // to equal the password, so the digit count is part of the comparison.
   assign w_match = (r_count == FULL_COUNT) && (r_code == PASSWORD);

   // Saturating decrement so the attempt counter can never wrap around.
   assign w_triesDec = (r_tries == '0) ? '0 : (r_tries - TRY_W'(1));

   // New digit enters at the LSBs; the oldest digit walks towards the MSBs.
   assign w_codeShifted = (r_code << DIGIT_W) | CODE_W'(digit_in);

   // State and datapath registers. Every output is taken straight from one
   // of these, so the status seen by the controller is glitch-free.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_ENTRY;
         r_auth  <= AUTH_WAIT;
         r_code  <= '0;
         r_count <= '0;
         r_tries <= TRIES_INIT;
         r_hold  <= '0;
      end else begin
         r_state <= w_stateNext;
         r_auth  <= w_authNext;
         r_code  <= w_codeNext;
         r_count <= w_countNext;
         r_tries <= w_triesNext;
         r_hold  <= w_holdNext;
      end
   end

   // Next-state and next-value logic. Everything holds by default; each
   // state only names the registers it changes. In ENTRY the strobes are
   // prioritised clear > enter > digit so that a coincident lower-priority
   // pulse is simply lost rather than remembered for later.
   always_comb begin
      w_stateNext = r_state;
      w_authNext  = r_auth;
      w_codeNext  = r_code;
      w_countNext = r_count;
      w_triesNext = r_tries;
      w_holdNext  = r_hold;

      case (r_state)
         ST_ENTRY: begin
            if (clear) begin
               w_codeNext  = '0;
               w_countNext = '0;
            end else if (enter) begin
               w_stateNext = ST_CHECK;
            end else if (digit_valid && (r_count < FULL_COUNT)) begin
               w_codeNext  = w_codeShifted;
               w_countNext = r_count + CNT_W'(1);
            end
         end

         // One-cycle evaluation. The status register is loaded here so the
         // verdict appears on the edge that leaves CHECK.
         ST_CHECK: begin
            if (w_match) begin
               w_stateNext = ST_PASS;
               w_authNext  = AUTH_OK;
            end else begin
               w_triesNext = w_triesDec;
               if (w_triesDec == '0) begin
                  w_stateNext = ST_LOCK;
                  w_authNext  = AUTH_LOCK;
               end else begin
                  w_stateNext = ST_FAIL;
                  w_authNext  = AUTH_BAD;
                  w_holdNext  = HOLD_LOAD;
               end
            end
         end

         ST_PASS: begin
         end

         // The hold counter is loaded with FAIL_HOLD-1 on entry; the status
         // is already showing "incorrect" for that first cycle, so reaching
         // zero marks the last of the FAIL_HOLD cycles. The stale entry is
         // wiped on the way back so the next attempt starts empty.
         ST_FAIL: begin
            if (r_hold == '0) begin
               w_stateNext = ST_ENTRY;
               w_authNext  = AUTH_WAIT;
               w_codeNext  = '0;
               w_countNext = '0;
            end else begin
               w_holdNext = r_hold - HOLD_W'(1);
            end
         end

         ST_LOCK: begin
            w_triesNext = '0;
         end

         default: begin
            w_stateNext = ST_ENTRY;
            w_authNext  = AUTH_WAIT;
            w_codeNext  = '0;
            w_countNext = '0;
         end
      endcase
   end

   assign s_auth      = r_auth;
   assign code_out    = r_code;
   assign digit_count = r_count;
   assign tries_left  = r_tries;

endmodule

// File: tb/tb_auth_unit.sv
// Testbench for auth_unit. Stimulus is issued attempt by attempt; a
// reference model working on lists of digits decides what each submit
// should produce and queues it. A monitor watches the status output and
// checks every change against the queue, independent of the driver.
module tb_auth_unit;

   localparam int          CODE_LEN  = 4;
   localparam int          DIGIT_W   = 4;
   localparam int          MAX_TRIES = 3;
   localparam int          FAIL_HOLD = 8;
   localparam logic [15:0] PASSWORD  = 16'h1234;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  digitIn = 4'd0;
   logic        digitValid = 1'b0;
   logic        enterPulse = 1'b0;
   logic        clearPulse = 1'b0;
   logic [1:0]  sAuth;
   logic [15:0] codeOut;
   logic [2:0]  digitCount;
   logic [1:0]  triesLeft;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   typedef struct {
      logic [1:0]  auth;
      int          tries;
      logic [15:0] code;
      int          cycle;
   } expItem_t;

   expItem_t expQ[$];

   // Reference model state: the digits accepted so far in this attempt,
   // attempts remaining, and whether a terminal verdict has been reached.
   int unsigned mDigits[$];
   int          mTries;
   bit          mDone;
   logic [1:0]  mFinal;

   logic [1:0]  monPrev = 2'b00;
   int          monHoldStart = 0;
   bit          monInHold = 1'b0;

   auth_unit #(
      .CODE_LEN  (CODE_LEN),
      .DIGIT_W   (DIGIT_W),
      .PASSWORD  (PASSWORD),
      .MAX_TRIES (MAX_TRIES),
      .FAIL_HOLD (FAIL_HOLD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .digit_in    (digitIn),
      .digit_valid (digitValid),
      .enter       (enterPulse),
      .clear       (clearPulse),
      .s_auth      (sAuth),
      .code_out    (codeOut),
      .digit_count (digitCount),
      .tries_left  (triesLeft)
   );

   // Free-running clock and a cycle counter used for latency checks.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Global watchdog so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic void modelReset();
      mDigits.delete();
      mTries = MAX_TRIES;
      mDone  = 1'b0;
      mFinal = 2'b00;
   endfunction

   function automatic void modelDigit(input int unsigned d);
      if (!mDone && mDigits.size() < CODE_LEN) mDigits.push_back(d);
   endfunction

   function automatic void modelClear();
      if (!mDone) mDigits.delete();
   endfunction

   // A submit: build the code from the digit list, decide the verdict,
   // and queue what the status output should show and when.
   function automatic void modelEnter(input int nowCyc);
      logic [15:0] code = 16'h0;
      expItem_t    e;
      if (mDone) return;
      foreach (mDigits[i]) code = (code << 4) | 16'(mDigits[i]);
      if (mDigits.size() == CODE_LEN && code == PASSWORD) begin
         e.auth = 2'b01;
         mDone  = 1'b1;
         mFinal = 2'b01;
      end else begin
         mTries = mTries - 1;
         if (mTries == 0) begin
            e.auth = 2'b11;
            mDone  = 1'b1;
            mFinal = 2'b11;
         end else begin
            e.auth = 2'b10;
         end
      end
      e.tries = mTries;
      e.code  = code;
      e.cycle = nowCyc + 2;
      expQ.push_back(e);
      mDigits.delete();
   endfunction

   // One clock of stimulus. Called at #1 after a rising edge; returns at
   // #1 after the next rising edge with all strobes low again.
   task automatic applyStimulus(input logic dv, input logic [3:0] d, input logic en, input logic clr);
      digitValid = dv;
      digitIn    = d;
      enterPulse = en;
      clearPulse = clr;
      if (clr)      modelClear();
      else if (en)  modelEnter(cyc);
      else if (dv)  modelDigit(int'(d));
      @(posedge clk);
      #1;
      digitValid = 1'b0;
      enterPulse = 1'b0;
      clearPulse = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   // Digits packed MSB-first, n of them, with random gaps between pulses.
   task automatic enterDigits(input logic [23:0] pk, input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, pk[(n-1-i)*4 +: 4], 1'b0, 1'b0);
         idle($urandom_range(0, 1));
      end
   endtask

   task automatic submit();
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
      idle(FAIL_HOLD + 3);
   endtask

   // Asynchronous reset: outputs are checked before any clock edge.
   task automatic doReset();
      digitValid = 1'b0;
      enterPulse = 1'b0;
      clearPulse = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput("reset_auth",  32'(sAuth),      32'd0);
      checkOutput("reset_code",  32'(codeOut),    32'd0);
      checkOutput("reset_count", 32'(digitCount), 32'd0);
      checkOutput("reset_tries", 32'(triesLeft),  32'(MAX_TRIES));
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      modelReset();
   endtask

   task automatic randomAttempt();
      logic [23:0] pk;
      int          n;
      if ($urandom_range(0, 3) == 0) begin
         n  = $urandom_range(1, 3);
         pk = 24'($urandom);
         enterDigits(pk, n);
         applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      end
      if ($urandom_range(0, 2) == 0) begin
         pk = 24'h001234;
         n  = 4;
         if ($urandom_range(0, 1) == 1) begin
            pk = {pk[19:0], 4'($urandom)};
            n  = 5;
         end
      end else begin
         n  = $urandom_range(0, 6);
         pk = 24'($urandom);
      end
      enterDigits(pk, n);
      submit();
   endtask

   // Monitor: samples on the falling edge. Any change of the status away
   // from "awaiting" must match the next queued verdict; a 10 -> 00 change
   // closes a hold window whose length and cleanup are checked.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            monPrev   = 2'b00;
            monInHold = 1'b0;
         end else if (sAuth !== monPrev) begin
            if (monPrev == 2'b00) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_result", 32'(sAuth), 32'd0);
               end else begin
                  expItem_t e;
                  e = expQ.pop_front();
                  checkOutput("result_auth",    32'(sAuth),     32'(e.auth));
                  checkOutput("result_tries",   32'(triesLeft), 32'(e.tries));
                  checkOutput("result_code",    32'(codeOut),   32'(e.code));
                  checkOutput("result_latency", 32'(cyc),       32'(e.cycle));
                  if (sAuth == 2'b10) begin
                     monInHold    = 1'b1;
                     monHoldStart = cyc;
                  end
               end
            end else if (monPrev == 2'b10 && sAuth == 2'b00 && monInHold) begin
               checkOutput("hold_length",     32'(cyc - monHoldStart), 32'(FAIL_HOLD));
               checkOutput("hold_exit_count", 32'(digitCount),         32'd0);
               checkOutput("hold_exit_code",  32'(codeOut),            32'd0);
               monInHold = 1'b0;
            end else begin
               checkOutput("auth_stable", 32'(sAuth), 32'(monPrev));
            end
            monPrev = sAuth;
         end
      end
   end

   initial begin
      #1;
      doReset();

      // Correct code, then the verdict must persist through more input.
      enterDigits(24'h001234, 4);
      submit();
      checkOutput("pass_auth", 32'(sAuth), 32'd1);
      enterDigits(24'h000567, 3);
      submit();
      checkOutput("pass_hold_auth",  32'(sAuth),     32'd1);
      checkOutput("pass_hold_code",  32'(codeOut),   32'h1234);
      checkOutput("pass_hold_tries", 32'(triesLeft), 32'(mTries));

      // Single failure followed by a correct retry.
      doReset();
      enterDigits(24'h001235, 4);
      submit();
      checkOutput("fail_tries", 32'(triesLeft),  32'(mTries));
      checkOutput("fail_count", 32'(digitCount), 32'd0);
      checkOutput("fail_auth",  32'(sAuth),      32'd0);
      enterDigits(24'h001234, 4);
      submit();
      checkOutput("retry_auth", 32'(sAuth), 32'd1);

      // Lockout after three wrong codes; a correct code no longer helps.
      doReset();
      repeat (MAX_TRIES) begin
         enterDigits(24'h009999, 4);
         submit();
      end
      checkOutput("lock_auth",  32'(sAuth),     32'd3);
      checkOutput("lock_tries", 32'(triesLeft), 32'd0);
      enterDigits(24'h001234, 4);
      submit();
      checkOutput("lock_stays", 32'(sAuth), 32'd3);

      // Overflow digit is dropped.
      doReset();
      enterDigits(24'h012349, 5);
      checkOutput("ovf_count", 32'(digitCount), 32'd4);
      checkOutput("ovf_code",  32'(codeOut),    32'h1234);
      submit();
      checkOutput("ovf_auth", 32'(sAuth), 32'd1);

      // Short entry fails.
      doReset();
      enterDigits(24'h000123, 3);
      submit();
      checkOutput("short_tries", 32'(triesLeft), 32'(mTries));

      // clear wins over enter.
      doReset();
      enterDigits(24'h001234, 4);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
      idle(3);
      checkOutput("clr_enter_count", 32'(digitCount), 32'd0);
      checkOutput("clr_enter_code",  32'(codeOut),    32'd0);
      checkOutput("clr_enter_auth",  32'(sAuth),      32'd0);

      // enter wins over a coincident digit.
      doReset();
      enterDigits(24'h000123, 3);
      applyStimulus(1'b1, 4'd4, 1'b1, 1'b0);
      idle(FAIL_HOLD + 3);
      checkOutput("enter_digit_tries", 32'(triesLeft), 32'(mTries));

      // Asynchronous reset on the third hold cycle.
      doReset();
      enterDigits(24'h000123, 3);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
      idle(3);
      checkOutput("midhold_auth", 32'(sAuth), 32'd2);
      doReset();

      // Randomised sessions.
      for (int s = 0; s < 15; s++) begin
         doReset();
         for (int a = 0; a < 5; a++) randomAttempt();
         checkOutput("session_auth",  32'(sAuth),     32'(mDone ? mFinal : 2'b00));
         checkOutput("session_tries", 32'(triesLeft), 32'(mTries));
      end

      for (int i = 0; i < 50 && expQ.size() != 0; i++) @(negedge clk);
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
